// File: rtl/press_word_assembler.sv
// Turns debounced button press durations into bits (short=0, long=1), packs them
// MSB-first into WIDTH-bit words and offers each word over a valid/ready handshake.
module press_word_assembler #(
  parameter int WIDTH     = 8,
  parameter int CNTW      = 16,
  parameter int LONGPRESS = 1000,
  parameter int TIMEOUT   = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       positiveedge,
  input  logic                       negativeedge,
  input  logic                       word_ready,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       long_flag,
  output logic                       aborted
);
  localparam int BCW = $clog2(WIDTH+1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] LP_THR   = CNTW'(LONGPRESS);
  localparam logic [CNTW-1:0] IDLE_END = CNTW'(TIMEOUT - 1);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  word_q;
  logic [BCW-1:0]    bcnt_q;
  logic              valid_q, long_q, abort_q;
  logic [CNTW-1:0]   hold_q, idle_q;
  logic [CNTW-1:0]   hold_d;
  logic              press, release_, press_bit;

  // Simultaneous edges are an upstream fault; neither is honoured.
  assign press     = positiveedge & ~negativeedge;
  assign release_  = negativeedge & ~positiveedge;
  assign press_bit = (hold_q >= LP_THR);
  // Saturate rather than wrap so a very long hold still reads as a 1.
  assign hold_d    = (hold_q == CNT_MAX) ? hold_q : hold_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
      long_q  <= 1'b0;
      abort_q <= 1'b0;
      hold_q  <= '0;
      idle_q  <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= HOLD;
            hold_q  <= '0;
            idle_q  <= '0;
          end else if (bcnt_q != '0) begin
            if (idle_q == IDLE_END) begin
              word_q  <= '0;
              bcnt_q  <= '0;
              idle_q  <= '0;
              abort_q <= 1'b1;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end else begin
            idle_q <= '0;
          end
        end
        HOLD: begin
          if (release_) begin
            word_q <= {word_q[WIDTH-2:0], press_bit};
            bcnt_q <= bcnt_q + 1'b1;
            long_q <= 1'b0;
            if (bcnt_q == LAST_BIT) begin
              state_q <= FULL;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            hold_q <= hold_d;
            long_q <= (hold_d >= LP_THR);
          end
        end
        FULL: begin
          if (word_ready) begin
            word_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign bit_count  = bcnt_q;
  assign long_flag  = long_q;
  assign aborted    = abort_q;
endmodule

// File: tb/tb_press_word_assembler.sv
// Scoreboarded bench: stimulus tasks feed a press-level model that queues expected
// words; an independent monitor checks every accepted word and every abort pulse.
module tb_press_word_assembler;
  localparam int W = 4, CW = 16, LP = 10, TO = 40;
  localparam int BCW = $clog2(W+1);

  logic clk = 1'b0, rst_n = 1'b0, pe = 1'b0, ne = 1'b0, rdy = 1'b0;
  logic [W-1:0]   word;
  logic           word_valid, long_flag, aborted;
  logic [BCW-1:0] bit_count;

  press_word_assembler #(.WIDTH(W), .CNTW(CW), .LONGPRESS(LP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .positiveedge(pe), .negativeedge(ne), .word_ready(rdy),
    .word(word), .word_valid(word_valid), .bit_count(bit_count),
    .long_flag(long_flag), .aborted(aborted));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_abort = 0, got_abort = 0;

  // Press-level reference: bits collected so far, idle gap, word-offered flag.
  int nbits = 0, gap = 0;
  logic [W-1:0] mword = '0;
  bit mfull = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit p, input bit n, input bit r);
    @(posedge clk); #1;
    pe = p; ne = n; rdy = r;
    @(negedge clk);
  endtask

  function automatic bit rnd_rdy();
    return mfull ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  task automatic model_reset();
    nbits = 0; gap = 0; mword = '0; mfull = 0;
  endtask

  task automatic idle(input int g);
    for (int i = 0; i < g; i++) begin
      step(0, 0, rnd_rdy());
      if (!mfull && nbits > 0) begin
        gap++;
        if (gap == TO) begin
          nbits = 0; mword = '0; gap = 0; exp_abort++;
        end
      end
    end
  endtask

  task automatic press(input int h);
    bit acc;
    acc = !mfull;
    step(1, 0, rnd_rdy());
    chk("bit_count_before_press", bit_count, mfull ? W : nbits);
    for (int j = 0; j < h; j++) begin
      step(0, 0, rnd_rdy());
      if (j == 0 || j == LP-1 || j == LP || j == h-1)
        chk("long_flag_hold", long_flag, (acc && j >= LP) ? 1 : 0);
    end
    step(0, 1, rnd_rdy());
    chk("long_flag_release", long_flag, (acc && h >= LP) ? 1 : 0);
    if (acc) begin
      mword = {mword[W-2:0], (h >= LP) ? 1'b1 : 1'b0};
      nbits++;
      gap = 0;
      if (nbits == W) begin
        exp_q.push_back(mword);
        mfull = 1;
      end
    end
  endtask

  task automatic handshake(input bit junk);
    step(junk, 0, 1);
    mfull = 0; nbits = 0; mword = '0; gap = 0;
  endtask

  task automatic fill_word();
    while (!mfull) begin
      press($urandom_range(0, 20));
      idle($urandom_range(0, 3));
    end
  endtask

  // Monitor: checks accepted words, word stability while offered, abort pulses.
  logic [W-1:0] prev_word;
  bit prev_valid = 0, prev_hs = 0, prev_abort = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0; prev_hs = 0; prev_abort = 0;
    end else begin
      if (aborted) begin
        got_abort++;
        if (prev_abort) begin
          errors++; checks++;
          $display("FAIL abort_pulse_width: got 2+ cycles expected 1 at %0t", $time);
        end
      end
      if (prev_valid && !prev_hs) begin
        chk("valid_held", word_valid, 1);
        chk("word_stable", word, prev_word);
      end
      if (word_valid && rdy) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", word, $time);
        end else begin
          chk("word", word, exp_q.pop_front());
        end
        chk("bit_count_full", bit_count, W);
      end
      prev_valid = word_valid; prev_word = word;
      prev_hs = word_valid && rdy; prev_abort = aborted;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    // Reset state, and a stray release straight after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_word", word, 0); chk("rst_valid", word_valid, 0);
    chk("rst_bcnt", bit_count, 0); chk("rst_long", long_flag, 0); chk("rst_abort", aborted, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(0, 1, 0); step(0, 0, 0);
    chk("stray_release_bcnt", bit_count, 0);

    // Holds 3,12,9,10 -> 0101
    press(3); idle(2); press(12); idle(3); press(9); idle(1); press(10);
    step(0, 0, 0);
    chk("t1_word", word, 4'b0101); chk("t1_valid", word_valid, 1); chk("t1_bcnt", bit_count, W);

    // Consumer stalls with extra presses arriving, then accepts
    idle(5); press(2); idle(3); press(12); idle(5);
    chk("t2_word_held", word, 4'b0101);
    handshake(0); step(0, 0, 0);
    chk("t2_valid_drop", word_valid, 0); chk("t2_bcnt", bit_count, 0);

    // 39 idle cycles keep a partial word, 40 discard it
    a0 = exp_abort;
    press(2); idle(1); press(3); idle(39); press(4); idle(1);
    chk("t3_bcnt3", bit_count, 3); chk("t3_no_abort", exp_abort, a0);
    idle(41);
    chk("t3_abort_count", got_abort, exp_abort); chk("t3_abort_model", exp_abort, a0 + 1);
    chk("t3_word_cleared", word, 0); chk("t3_bcnt_cleared", bit_count, 0);

    // Reset mid-HOLD with two bits captured and long_flag already up
    press(2); idle(1); press(11); idle(2);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    chk("t4_long_before_rst", long_flag, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    chk("t4_word", word, 0); chk("t4_bcnt", bit_count, 0);
    chk("t4_long", long_flag, 0); chk("t4_valid", word_valid, 0);
    step(0, 1, 0); step(0, 0, 0);
    chk("t4_release_ignored", bit_count, 0);
    fill_word(); idle(2); handshake(0);

    // Hold past counter range: must saturate (a wrap would leave hold_cnt=5 -> 0)
    press(65541); idle(1);
    chk("t5_sat_bit", word[0], 1);
    fill_word(); handshake(0);

    // Handshake coincides with a press: press dropped, block idles
    fill_word(); idle(2); handshake(1);
    idle(12);
    chk("t6_valid", word_valid, 0); chk("t6_bcnt", bit_count, 0);
    chk("t6_not_holding", long_flag, 0);

    // Randomized press/idle/handshake traffic
    for (int it = 0; it < 300; it++) begin
      if (mfull) begin
        if ($urandom_range(0, 2) == 0) press($urandom_range(0, 15));
        else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 6));
        else handshake(1'($urandom_range(0, 1)));
      end else begin
        press($urandom_range(0, 20));
        if ($urandom_range(0, 7) == 0) idle($urandom_range(35, 45));
        else idle($urandom_range(0, 10));
      end
    end
    if (mfull) handshake(0);
    step(0, 0, 0); step(0, 0, 0);
    chk("all_words_seen", exp_q.size(), 0);
    chk("abort_total", got_abort, exp_abort);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
